// File: rtl/jtag_host.sv
// JTAG initiator: runs TAP reset, IR scan or DR scan one command at a time and returns captured TDO.
// Optional JTAG_HOST_TRST_EN adds an active-high trst output driven for the duration of a RESET command.
module jtag_host #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic               trst
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] T_RST = 2'd0;
  localparam logic [1:0] T_IR  = 2'd1;

  logic [2:0]         state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [5:0]         bit_q, bit_d;
  logic [5:0]         len_q, len_d;
  logic [1:0]         type_q, type_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] data_sh;
  logic [5:0]         n_clamp;
  logic [5:0]         pre_last;
  logic               load;

  // TMS value for a given TCK cycle of the walk from Run-Test/Idle back to Run-Test/Idle
  function automatic logic tms_of(input logic [2:0] st, input logic [5:0] b,
                                  input logic [1:0] ty, input logic [5:0] n);
    logic v;
    v = 1'b0;
    case (st)
      S_PRE: begin
        if (ty == T_RST)     v = (b < 6'd5);
        else if (ty == T_IR) v = (b < 6'd2);
        else                 v = (b < 6'd1);
      end
      S_SHIFT: v = (b == n - 6'd1);
      S_POST:  v = (b == 6'd0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  always_comb begin
    n_clamp = cmd_len;
    if (32'(cmd_len) > MAX_LEN) n_clamp = 6'(MAX_LEN);
  end

  assign pre_last = (type_q == T_RST) ? 6'd5 : (type_q == T_IR) ? 6'd3 : 6'd2;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    bit_d   = bit_q;
    len_d   = len_q;
    type_d  = type_q;
    data_d  = data_q;
    cap_d   = cap_q;
    data_sh = '0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          type_d  = (cmd_type == 2'd3) ? T_RST : cmd_type;
          len_d   = n_clamp;
          data_d  = cmd_data;
          cap_d   = '0;
          div_d   = '0;
          tck_d   = 1'b0;
          bit_d   = '0;
          state_d = S_PRE;
          load    = (type_d == T_RST) || (n_clamp != 6'd0);
        end
      end
      S_PRE, S_SHIFT, S_POST: begin
        if (state_q == S_PRE && type_q != T_RST && len_q == 6'd0) begin
          state_d = S_RESP;
        end else if (div_q != DW'(CLK_DIV - 1)) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
            if (state_q == S_SHIFT)
              cap_d = cap_q | ({{(MAX_LEN-1){1'b0}}, tdo} << bit_q);
          end else begin
            // falling edge: advance to the next TCK cycle and present its tms/tdi
            tck_d = 1'b0;
            load  = 1'b1;
            bit_d = bit_q + 6'd1;
            case (state_q)
              S_PRE: if (bit_q == pre_last) begin
                bit_d   = '0;
                state_d = (type_q == T_RST) ? S_RESP : S_SHIFT;
              end
              S_SHIFT: if (bit_q == len_q - 6'd1) begin
                bit_d   = '0;
                state_d = S_POST;
              end
              default: if (bit_q == 6'd1) begin
                bit_d   = '0;
                state_d = S_RESP;
              end
            endcase
          end
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      data_sh = data_d >> bit_d;
      tdi_d   = (state_d == S_SHIFT) && data_sh[0];
      if (state_d != S_RESP) tms_d = tms_of(state_d, bit_d, type_d, len_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      bit_q   <= '0;
      len_q   <= '0;
      type_q  <= T_RST;
      data_q  <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      type_q  <= type_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
    end
  end

`ifdef JTAG_HOST_TRST_EN
  logic trst_q, trst_d;

  always_comb begin
    trst_d = trst_q;
    if (state_q == S_IDLE && cmd_valid && type_d == T_RST) trst_d = 1'b1;
    if (state_d == S_RESP) trst_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trst_q <= 1'b0;
    else        trst_q <= trst_d;
  end

  assign trst = trst_q;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = cap_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: loopback flop and a small TAP target model drive tdo; responses checked via a scoreboard.
module tb_jtag_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, tdo;
`ifdef JTAG_HOST_TRST_EN
  logic        trst;
`endif

  jtag_host #(.CLK_DIV(2), .MAX_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef JTAG_HOST_TRST_EN
    , .trst(trst)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // tdo sources: 1-bit loopback flop in the tck domain, or a TAP model with a 4-bit IR
  logic tdo_sel = 1'b0;
  logic lb_q;
  logic tap_tdo;
  logic tap_rst_n = 1'b0;
  assign tdo = tdo_sel ? tap_tdo : lb_q;

  always @(posedge tck or negedge rst_n)
    if (!rst_n) lb_q <= 1'b0;
    else        lb_q <= tdi;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
  int         tap_st;
  logic [3:0] ir_sr, ir_reg;

  always @(posedge tck or negedge tap_rst_n) begin
    if (!tap_rst_n) begin
      tap_st <= TLR;
      ir_sr  <= 4'd0;
      ir_reg <= 4'hF;
    end else begin
      if (tap_st == CAPIR) ir_sr <= 4'b0001;
      if (tap_st == SHIR)  ir_sr <= {tdi, ir_sr[3:1]};
      if (tap_st == UPIR)  ir_reg <= ir_sr;
      case (tap_st)
        TLR:   tap_st <= tms ? TLR   : RTI;
        RTI:   tap_st <= tms ? SELDR : RTI;
        SELDR: tap_st <= tms ? SELIR : CAPDR;
        CAPDR: tap_st <= tms ? EX1DR : SHDR;
        SHDR:  tap_st <= tms ? EX1DR : SHDR;
        EX1DR: tap_st <= tms ? UPDR  : PADR;
        PADR:  tap_st <= tms ? EX2DR : PADR;
        EX2DR: tap_st <= tms ? UPDR  : SHDR;
        UPDR:  tap_st <= tms ? SELDR : RTI;
        SELIR: tap_st <= tms ? TLR   : CAPIR;
        CAPIR: tap_st <= tms ? EX1IR : SHIR;
        SHIR:  tap_st <= tms ? EX1IR : SHIR;
        EX1IR: tap_st <= tms ? UPIR  : PAIR;
        PAIR:  tap_st <= tms ? EX2IR : PAIR;
        EX2IR: tap_st <= tms ? UPIR  : SHIR;
        default: tap_st <= tms ? SELDR : RTI;
      endcase
    end
  end

  always @(negedge tck or negedge tap_rst_n)
    if (!tap_rst_n)          tap_tdo <= 1'b0;
    else if (tap_st == SHIR) tap_tdo <= ir_sr[0];
    else                     tap_tdo <= 1'b0;

  // per-command TCK log: tms/tdi at each rising edge, and period in clks
  int          tck_cnt = 0;
  int          prev_cyc = 0;
  int          bad_period = 0;
  logic [63:0] tms_vec = '0;
  logic [63:0] tdi_vec = '0;
  always @(posedge tck) begin
    if (tck_cnt < 64) begin
      tms_vec[tck_cnt] = tms;
      tdi_vec[tck_cnt] = tdi;
    end
    if (tck_cnt > 0 && cyc - prev_cyc != 4) bad_period++;
    prev_cyc = cyc;
    tck_cnt++;
  end

  int trst_cnt = 0;
`ifdef JTAG_HOST_TRST_EN
  always @(negedge clk) if (trst === 1'b1) trst_cnt++;
`endif

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          tcks_q[$];
  int          acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] ty, input logic [5:0] len, input logic [31:0] data,
                      input logic [31:0] exp, input int lat, input int ntck);
    int n;
    @(negedge clk);
    tck_cnt = 0; bad_period = 0; tms_vec = '0; tdi_vec = '0; trst_cnt = 0;
    cmd_valid = 1'b1; cmd_type = ty; cmd_len = len; cmd_data = data;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    tcks_q.push_back(ntck);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic pop_compare(input string tag);
    logic [31:0] e;
    int          l, t;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    t = tcks_q.pop_front();
    check({tag, "_data"}, 64'(rsp_data), 64'(e));
    check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(l));
    check({tag, "_tck_count"}, 64'(tck_cnt), 64'(t));
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rsp_valid_after"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] d40;
    logic [31:0] dummy;
    int          bad, n, t0;

    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    tap_rst_n = 1'b1;

    // TAP reset
    send(2'd0, 6'd9, 32'hFFFF_FFFF, 32'd0, 24, 6);
    wait_valid();
    pop_compare("reset");
    check("reset_tms_pattern", tms_vec, 64'h1F);
    check("reset_tck_period", 64'(bad_period), 64'd0);
    check("reset_tap_state", 64'(tap_st), 64'(RTI));
`ifdef JTAG_HOST_TRST_EN
    check("reset_trst_clks", 64'(trst_cnt), 64'd24);
`endif
    consume("reset");

    // DR scan through the loopback flop: each sample is the previous cycle's tdi
    send(2'd2, 6'd8, 32'hA5, 32'h4A, 52, 13);
    wait_valid();
    pop_compare("dr8");
    check("dr8_tms_pattern", tms_vec, 64'hC01);
    check("dr8_tdi_pattern", tdi_vec, 64'h528);
    check("dr8_tck_period", 64'(bad_period), 64'd0);
    check("dr8_trst_clks", 64'(trst_cnt), 64'd0);
    consume("dr8");

    // IR scan against the TAP model: capture value 4'b0001 comes back, IR updates to data
    tdo_sel = 1'b1;
    send(2'd1, 6'd4, 32'h1, 32'h1, 40, 10);
    wait_valid();
    pop_compare("ir4");
    check("ir4_tms_pattern", tms_vec, 64'h183);
    check("ir4_ir_update", 64'(ir_reg), 64'h1);
    check("ir4_tap_state", 64'(tap_st), 64'(RTI));
    consume("ir4");
    tdo_sel = 1'b0;

    // zero-length DR scan
    send(2'd2, 6'd0, 32'hFFFF_FFFF, 32'd0, 1, 0);
    wait_valid();
    pop_compare("dr0");
    consume("dr0");

    // length 40 clamps to 32 shift cycles
    d40 = 32'hDEAD_BEEF;
    send(2'd2, 6'd40, d40, d40 << 1, 148, 37);
    wait_valid();
    pop_compare("dr40");
    check("dr40_tck_period", 64'(bad_period), 64'd0);
    check("dr40_tap_state", 64'(tap_st), 64'(RTI));
    consume("dr40");

    // held response: outputs stable, a second command is not taken
    send(2'd2, 6'd8, 32'h3C, 32'h78, 52, 13);
    wait_valid();
    pop_compare("hold");
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_len = 6'd0;
    t0 = tck_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h78 || cmd_ready !== 1'b0) bad++;
    end
    check("hold_stable_clks", 64'(bad), 64'd0);
    check("hold_no_tck", 64'(tck_cnt), 64'(t0));
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("hold_release_cmd_ready", 64'(cmd_ready), 64'd1);
    check("hold_release_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("hold_second_cmd_ignored", 64'(cmd_ready), 64'd1);

    // reset in the middle of a shift
    send(2'd2, 6'd32, 32'h0, 32'd0, 0, 0);
    dummy = exp_q.pop_front();
    n = lat_q.pop_front();
    n = tcks_q.pop_front();
    n = 0;
    while (!(tck_cnt >= 6 && tck === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midshift_reached", 64'(tck), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midshift_tck", 64'(tck), 64'd0);
    check("midshift_tms", 64'(tms), 64'd1);
    check("midshift_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(2'd3, 6'd0, 32'h0, 32'd0, 24, 6);
    wait_valid();
    pop_compare("rerst");
    check("rerst_tms_pattern", tms_vec, 64'h1F);
    check("rerst_tap_state", 64'(tap_st), 64'(RTI));
`ifdef JTAG_HOST_TRST_EN
    check("rerst_trst_clks", 64'(trst_cnt), 64'd24);
`endif
    consume("rerst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
